// File: rtl/ascii_num_stream_parser.sv
// Splits an ASCII byte stream into delimiter-separated signed integers and emits
// them one at a time on a valid/ready port; 1-cycle latency, full input backpressure while emitting.
module ascii_num_stream_parser #(
  parameter int DATA_W        = 32,
  parameter int MAX_COUNT     = 2048,
  parameter int CNT_W         = $clog2(MAX_COUNT + 1),
  parameter int ALLOW_COMMA   = 1,
  parameter int ALLOW_NEWLINE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              num_valid,
  input  logic              num_ready,
  output logic [DATA_W-1:0] num_data,
  output logic              num_last,
  output logic [CNT_W-1:0]  num_count,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int AW = DATA_W + 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SKIP,
    ST_ACCUM,
    ST_EMIT,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t              state_q;
  logic [AW-1:0]       acc_q;
  logic                neg_q;
  logic                digits_q;
  logic                pend_done_q;
  logic                in_ready_q;
  logic                num_valid_q;
  logic [DATA_W-1:0]   num_data_q;
  logic                num_last_q;
  logic [CNT_W-1:0]    num_count_q;
  logic                done_q;
  logic                err_q;
  logic [1:0]          err_code_q;

  logic                fire;
  logic                in_skip;
  logic                is_digit;
  logic                is_minus;
  logic                is_delim;
  logic [3:0]          digit;
  logic                neg_eff;
  logic [AW-1:0]       acc_base;
  logic [AW-1:0]       acc_d;
  logic [AW-1:0]       lim_pos;
  logic [AW-1:0]       lim;
  logic                ovf;
  logic                bad_char;
  logic                val_ovf;
  logic                tok_end;
  logic [AW-1:0]       term_acc;
  logic [DATA_W-1:0]   term_mag;
  logic [DATA_W-1:0]   term_data_d;
  logic                count_full;

  always_comb begin
    fire     = in_valid && in_ready_q;
    in_skip  = (state_q == ST_SKIP);
    is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
    is_minus = (in_data == 8'h2D);
    is_delim = (in_data == 8'h20) ||
               ((ALLOW_COMMA != 0) && (in_data == 8'h2C)) ||
               ((ALLOW_NEWLINE != 0) && ((in_data == 8'h0A) || (in_data == 8'h0D)));
    digit    = in_data[3:0];

    // A digit seen in SKIP starts a fresh positive token.
    neg_eff  = in_skip ? 1'b0 : neg_q;
    acc_base = in_skip ? '0 : acc_q;
    acc_d    = acc_base * AW'(10) + AW'(digit);
    lim_pos  = {{5{1'b0}}, {(DATA_W-1){1'b1}}};
    lim      = neg_eff ? (lim_pos + AW'(1)) : lim_pos;
    ovf      = acc_d > lim;

    bad_char = in_skip ? ((!is_delim && !is_digit && !is_minus) || (is_minus && in_last))
                       : (is_minus || (!is_digit && !is_delim) || (is_delim && !digits_q));
    val_ovf  = is_digit && ovf;
    tok_end  = (is_digit && in_last) || (!in_skip && is_delim);

    term_acc    = is_digit ? acc_d : acc_q;
    term_mag    = term_acc[DATA_W-1:0];
    term_data_d = neg_eff ? -term_mag : term_mag;
    count_full  = (num_count_q == CNT_W'(MAX_COUNT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      neg_q       <= 1'b0;
      digits_q    <= 1'b0;
      pend_done_q <= 1'b0;
      in_ready_q  <= 1'b0;
      num_valid_q <= 1'b0;
      num_data_q  <= '0;
      num_last_q  <= 1'b0;
      num_count_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
    end else if (clear) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      num_valid_q <= 1'b0;
      num_data_q  <= '0;
      num_last_q  <= 1'b0;
      num_count_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
      pend_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_SKIP;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            digits_q    <= 1'b0;
            pend_done_q <= 1'b0;
            num_count_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
            in_ready_q  <= 1'b1;
          end
        end

        ST_SKIP, ST_ACCUM: begin
          if (fire) begin
            if (bad_char) begin
              state_q    <= ST_ERROR;
              err_q      <= 1'b1;
              err_code_q <= 2'd1;
              in_ready_q <= 1'b0;
            end else if (val_ovf) begin
              state_q    <= ST_ERROR;
              err_q      <= 1'b1;
              err_code_q <= 2'd2;
              in_ready_q <= 1'b0;
            end else if (tok_end) begin
              in_ready_q <= 1'b0;
              if (count_full) begin
                state_q    <= ST_ERROR;
                err_q      <= 1'b1;
                err_code_q <= 2'd3;
              end else begin
                // A delimiter carrying in_last ends the stream after this number.
                state_q     <= ST_EMIT;
                num_valid_q <= 1'b1;
                num_data_q  <= term_data_d;
                num_last_q  <= is_digit;
                pend_done_q <= is_delim && in_last;
              end
            end else if (is_delim) begin
              if (in_last) begin
                state_q    <= ST_DONE;
                done_q     <= 1'b1;
                in_ready_q <= 1'b0;
              end
            end else if (is_digit) begin
              state_q  <= ST_ACCUM;
              acc_q    <= acc_d;
              neg_q    <= neg_eff;
              digits_q <= 1'b1;
            end else begin
              state_q  <= ST_ACCUM;
              acc_q    <= '0;
              neg_q    <= 1'b1;
              digits_q <= 1'b0;
            end
          end
        end

        ST_EMIT: begin
          if (num_ready) begin
            num_valid_q <= 1'b0;
            num_count_q <= num_count_q + CNT_W'(1);
            if (num_last_q || pend_done_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= ST_SKIP;
              in_ready_q <= 1'b1;
              acc_q      <= '0;
              neg_q      <= 1'b0;
              digits_q   <= 1'b0;
            end
          end
        end

        ST_DONE, ST_ERROR: begin
          in_ready_q <= 1'b0;
        end

        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign num_valid = num_valid_q;
  assign num_data  = num_data_q;
  assign num_last  = num_last_q;
  assign num_count = num_count_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_ascii_num_stream_parser.sv
// Bench for ascii_num_stream_parser: directed vector table, clear corner case and
// random streams against a token-level reference model.
module tb_ascii_num_stream_parser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0, clear = 1'b0, in_valid = 1'b0, in_last = 1'b0, num_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic sel = 1'b0;
  int   ready_mode = 0;

  logic        a_in_ready, a_num_valid, a_num_last, a_done, a_err;
  logic [31:0] a_num_data;
  logic [11:0] a_num_count;
  logic [1:0]  a_err_code;
  logic        b_in_ready, b_num_valid, b_num_last, b_done, b_err;
  logic [31:0] b_num_data;
  logic [1:0]  b_num_count;
  logic [1:0]  b_err_code;

  ascii_num_stream_parser #(.DATA_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_last(in_last),
    .num_valid(a_num_valid), .num_ready(num_ready), .num_data(a_num_data),
    .num_last(a_num_last), .num_count(a_num_count), .done(a_done), .err(a_err),
    .err_code(a_err_code));

  ascii_num_stream_parser #(.DATA_W(32), .MAX_COUNT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_last(in_last),
    .num_valid(b_num_valid), .num_ready(num_ready), .num_data(b_num_data),
    .num_last(b_num_last), .num_count(b_num_count), .done(b_done), .err(b_err),
    .err_code(b_err_code));

  logic        in_ready, num_valid, num_last, done, err;
  logic [31:0] num_data;
  logic [11:0] num_count;
  logic [1:0]  err_code;
  assign in_ready  = sel ? b_in_ready  : a_in_ready;
  assign num_valid = sel ? b_num_valid : a_num_valid;
  assign num_data  = sel ? b_num_data  : a_num_data;
  assign num_last  = sel ? b_num_last  : a_num_last;
  assign num_count = sel ? 12'(b_num_count) : a_num_count;
  assign done      = sel ? b_done      : a_done;
  assign err       = sel ? b_err       : a_err;
  assign err_code  = sel ? b_err_code  : a_err_code;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: num_ready = 1'b1;
      1: num_ready = ~num_ready;
      2: num_ready = 1'($urandom_range(0, 1));
      default: num_ready = 1'b0;
    endcase
  end

  // Output monitor: collects accepted numbers, checks stability under stall.
  int          got_d[$];
  bit          got_l[$];
  logic        hold_v = 1'b0;
  logic [31:0] hold_d;
  logic        hold_l;
  always @(negedge clk) begin
    if (rst_n && !clear) begin
      if (hold_v) begin
        chk("stall_valid", longint'(num_valid), 1);
        chk("stall_data", longint'(num_data), longint'(hold_d));
        chk("stall_last", longint'(num_last), longint'(hold_l));
      end
      if (num_valid) chk("in_ready_during_emit", longint'(in_ready), 0);
      if (num_valid && num_ready) begin
        got_d.push_back(int'(num_data));
        got_l.push_back(num_last);
      end
      hold_v = num_valid && !num_ready;
      hold_d = num_data;
      hold_l = num_last;
    end else begin
      hold_v = 1'b0;
    end
  end

  // Reference model: splits the text into tokens and evaluates each one.
  longint exp_d[$];
  bit     exp_l[$];
  int     m_nbytes, m_code;
  bit     m_done;

  function automatic bit is_delim(input byte c);
    return (c == " ") || (c == ",") || (c == 8'h0A) || (c == 8'h0D);
  endfunction

  task automatic model(input string s, input int max_cnt);
    int n, i, j, cnt, term;
    bit neg, dig;
    longint val, lim;
    byte c;
    exp_d.delete();
    exp_l.delete();
    n = s.len();
    m_nbytes = n;
    m_code = 0;
    cnt = 0;
    i = 0;
    while (i < n && m_code == 0) begin
      if (is_delim(s[i])) begin
        i++;
      end else begin
        neg = 0; dig = 0; val = 0;
        j = i;
        while (j < n && !is_delim(s[j]) && m_code == 0) begin
          c = s[j];
          if (c == "-" && j == i) neg = 1;
          else if (c >= "0" && c <= "9") begin
            val = val * 10 + longint'(c - "0");
            dig = 1;
            lim = neg ? 64'sd2147483648 : 64'sd2147483647;
            if (val > lim) m_code = 2;
          end else m_code = 1;
          if (m_code != 0) m_nbytes = j + 1;
          j++;
        end
        if (m_code == 0) begin
          term = (j < n) ? j : n - 1;
          if (!dig) m_code = 1;
          else if (cnt == max_cnt) m_code = 3;
          else begin
            exp_d.push_back(neg ? -val : val);
            exp_l.push_back(j == n);
            cnt++;
          end
          if (m_code != 0) m_nbytes = term + 1;
        end
        i = j;
      end
    end
    m_done = (m_code == 0);
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte was accepted.
  task automatic send_byte(input byte b, input bit l);
    int t;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = l;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 300);
    if (t >= 300) chk("byte_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_stream(input string s, input int mode, input bit sl,
                            input int t_done, input int t_code, input int t_cnt);
    int t;
    sel = sl;
    ready_mode = mode;
    got_d.delete();
    got_l.delete();
    model(s, sl ? 2 : 2048);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < m_nbytes; i++) send_byte(s[i], i == s.len() - 1);
    t = 0;
    while (!(done || err) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("finish_timeout", longint'(t < 500), 1);
    @(posedge clk);
    #1;
    chk("done", longint'(done), longint'(m_done));
    chk("err", longint'(err), longint'(!m_done));
    chk("err_code", longint'(err_code), longint'(m_code));
    chk("num_count", longint'(num_count), longint'(exp_d.size()));
    chk("in_ready_after", longint'(in_ready), 0);
    chk("num_valid_after", longint'(num_valid), 0);
    chk("n_numbers", longint'(got_d.size()), longint'(exp_d.size()));
    for (int k = 0; k < got_d.size() && k < exp_d.size(); k++) begin
      chk("value", longint'(got_d[k]), exp_d[k]);
      chk("last", longint'(got_l[k]), longint'(exp_l[k]));
    end
    if (t_done >= 0) begin
      chk("tbl_done", longint'(done), longint'(t_done));
      chk("tbl_code", longint'(err_code), longint'(t_code));
      chk("tbl_count", longint'(num_count), longint'(t_cnt));
    end
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  typedef struct {
    string s;
    int    mode;
    bit    sel;
    int    done;
    int    code;
    int    cnt;
  } vec_t;

  vec_t  vt[9];
  string delims[4];

  initial begin
    string s, piece;
    int t, ntok;
    longint v;

    vt[0] = '{"12 -7,  300\n",          0, 1'b0, 1, 0, 3};
    vt[1] = '{"5 6",                    1, 1'b0, 1, 0, 2};
    vt[2] = '{"-2147483648 2147483648", 0, 1'b0, 0, 2, 1};
    vt[3] = '{"4 - 3",                  0, 1'b0, 0, 1, 1};
    vt[4] = '{"4a",                     0, 1'b0, 0, 1, 0};
    vt[5] = '{"1 2 3",                  0, 1'b1, 0, 3, 2};
    vt[6] = '{"  2147483647,-0\r",      2, 1'b0, 1, 0, 2};
    vt[7] = '{"-",                      0, 1'b0, 0, 1, 0};
    vt[8] = '{"1 2",                    1, 1'b1, 1, 0, 2};
    delims[0] = " ";
    delims[1] = ",";
    delims[2] = "\n";
    delims[3] = "\r";

    #12;
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_num_valid", longint'(num_valid), 0);
    chk("rst_num_data", longint'(num_data), 0);
    chk("rst_num_count", longint'(num_count), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_err", longint'(err), 0);
    chk("rst_err_code", longint'(err_code), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++)
      run_stream(vt[i].s, vt[i].mode, vt[i].sel, vt[i].done, vt[i].code, vt[i].cnt);

    // clear while a number is waiting: it must be dropped
    sel = 1'b0;
    ready_mode = 3;
    got_d.delete();
    got_l.delete();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    send_byte("7", 1'b0);
    send_byte(" ", 1'b0);
    t = 0;
    while (!num_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("clr_num_valid_before", longint'(num_valid), 1);
    @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clr_num_valid", longint'(num_valid), 0);
    chk("clr_num_count", longint'(num_count), 0);
    chk("clr_in_ready", longint'(in_ready), 0);
    chk("clr_dropped", longint'(got_d.size()), 0);
    run_stream("9", 0, 1'b0, 1, 0, 1);

    // random streams
    for (int r = 0; r < 40; r++) begin
      s = "";
      ntok = $urandom_range(1, 5);
      for (int k = 0; k < ntok; k++) begin
        for (int d = 0; d < int'($urandom_range(0, 2)); d++) s = {s, delims[$urandom_range(0, 3)]};
        if (k > 0) s = {s, delims[$urandom_range(0, 3)]};
        case ($urandom_range(0, 15))
          0: piece = "-";
          1: piece = "1x";
          2, 3: begin
            v = 64'sd2147483645 + longint'($urandom_range(0, 5));
            if ($urandom_range(0, 1) == 1) v = -v;
            piece = $sformatf("%0d", v);
          end
          4, 5, 6: piece = $sformatf("%0d", longint'($urandom_range(0, 2000000)) * (($urandom_range(0, 1) == 1) ? -1 : 1));
          default: piece = $sformatf("%0d", longint'($urandom_range(0, 999)) * (($urandom_range(0, 2) == 0) ? -1 : 1));
        endcase
        s = {s, piece};
      end
      if ($urandom_range(0, 1) == 1) s = {s, delims[$urandom_range(0, 3)]};
      run_stream(s, $urandom_range(0, 2), ($urandom_range(0, 3) == 0), -1, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
